// File: rtl/mux_8to1.sv
// rtl/mux_8to1.sv - 8-lane selector with registered (default) or combinational output.
module mux_8to1 #(
   parameter int WIDTH   = 1,
   parameter bit REG_OUT = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [8*WIDTH-1:0]   in,
   input  logic [2:0]           sel,
   input  logic                 in_valid,
   output logic [WIDTH-1:0]     out,
   output logic                 out_valid,
   output logic [2:0]           sel_q
);

   logic [WIDTH-1:0] lane_sel;

   always_comb begin
      case (sel)
         3'd0:    lane_sel = in[0*WIDTH +: WIDTH];
         3'd1:    lane_sel = in[1*WIDTH +: WIDTH];
         3'd2:    lane_sel = in[2*WIDTH +: WIDTH];
         3'd3:    lane_sel = in[3*WIDTH +: WIDTH];
         3'd4:    lane_sel = in[4*WIDTH +: WIDTH];
         3'd5:    lane_sel = in[5*WIDTH +: WIDTH];
         3'd6:    lane_sel = in[6*WIDTH +: WIDTH];
         3'd7:    lane_sel = in[7*WIDTH +: WIDTH];
         default: lane_sel = in[0*WIDTH +: WIDTH];
      endcase
   end

   generate
      if (REG_OUT) begin : g_reg
         logic [WIDTH-1:0] out_q, out_d;
         logic [2:0]       sel_q_q, sel_q_d;
         logic             valid_q, valid_d;

         // Data and select hold across invalid cycles; only valid drops.
         always_comb begin
            out_d   = out_q;
            sel_q_d = sel_q_q;
            valid_d = in_valid;
            if (in_valid) begin
               out_d   = lane_sel;
               sel_q_d = sel;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               out_q   <= '0;
               sel_q_q <= '0;
               valid_q <= 1'b0;
            end else begin
               out_q   <= out_d;
               sel_q_q <= sel_q_d;
               valid_q <= valid_d;
            end
         end

         assign out       = out_q;
         assign sel_q     = sel_q_q;
         assign out_valid = valid_q;
      end else begin : g_comb
         logic unused_clk_rst;
         assign unused_clk_rst = &{1'b0, clk, rst_n};

         assign out       = lane_sel;
         assign sel_q     = sel;
         assign out_valid = in_valid;
      end
   endgenerate

endmodule

// File: tb/tb_mux_8to1.sv
// tb/tb_mux_8to1.sv - self-checking bench: registered 1-bit and 8-bit lanes, combinational 1-bit.
module tb_mux_8to1;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [7:0]  in1 = '0;  logic [2:0] sel1 = '0; logic v1 = 1'b0;
   logic        out1;      logic [2:0] sq1;       logic ov1;
   logic [63:0] in8 = '0;  logic [2:0] sel8 = '0; logic v8 = 1'b0;
   logic [7:0]  out8;      logic [2:0] sq8;       logic ov8;
   logic [7:0]  inc = '0;  logic [2:0] selc = '0; logic vc = 1'b0;
   logic        outc;      logic [2:0] sqc;       logic ovc;

   int checks = 0;
   int errors = 0;

   mux_8to1 #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel1), .in_valid(v1),
      .out(out1), .out_valid(ov1), .sel_q(sq1));
   mux_8to1 #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel8), .in_valid(v8),
      .out(out8), .out_valid(ov8), .sel_q(sq8));
   mux_8to1 #(.WIDTH(1), .REG_OUT(1'b0)) u_comb (
      .clk(clk), .rst_n(rst_n), .in(inc), .sel(selc), .in_valid(vc),
      .out(outc), .out_valid(ovc), .sel_q(sqc));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: lane k is bits [k*W +: W], i.e. a right shift by k*W then truncation.
   logic       m1_out; logic [2:0] m1_sel; logic m1_v;
   logic [7:0] m8_out; logic [2:0] m8_sel; logic m8_v;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m1_out <= 1'b0; m1_sel <= 3'd0; m1_v <= 1'b0;
         m8_out <= 8'h00; m8_sel <= 3'd0; m8_v <= 1'b0;
      end else begin
         m1_v <= v1;
         m8_v <= v8;
         if (v1) begin
            m1_out <= 1'((in1 >> sel1));
            m1_sel <= sel1;
         end
         if (v8) begin
            m8_out <= 8'((in8 >> (8 * sel8)));
            m8_sel <= sel8;
         end
      end
   end

   always @(negedge clk) begin
      chk("model_w1_out", 64'(out1), 64'(m1_out));
      chk("model_w1_selq", 64'(sq1), 64'(m1_sel));
      chk("model_w1_valid", 64'(ov1), 64'(m1_v));
      chk("model_w8_out", 64'(out8), 64'(m8_out));
      chk("model_w8_selq", 64'(sq8), 64'(m8_sel));
      chk("model_w8_valid", 64'(ov8), 64'(m8_v));
      chk("model_comb_out", 64'(outc), 64'(1'((inc >> selc))));
      chk("model_comb_selq", 64'(sqc), 64'(selc));
      chk("model_comb_valid", 64'(ovc), 64'(vc));
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #3 rst_n = 1'b0;
      #1;
      chk("reset_out", 64'(out1), 64'd0);
      chk("reset_valid", 64'(ov1), 64'd0);
      // Combinational instance ignores reset.
      inc = 8'b1111_0000; selc = 3'd4; vc = 1'b1;
      #1;
      chk("comb_in_reset_out", 64'(outc), 64'd1);
      chk("comb_in_reset_selq", 64'(sqc), 64'd4);
      repeat (2) step();
      rst_n = 1'b1;

      // Alternating pattern, one select per cycle.
      in1 = 8'b1010_1010; v1 = 1'b1;
      for (int s = 0; s < 8; s++) begin
         sel1 = 3'(s);
         step();
         chk("alt_out", 64'(out1), 64'(s % 2));
         chk("alt_selq", 64'(sq1), 64'(s));
         chk("alt_valid", 64'(ov1), 64'd1);
      end

      // Nibble pattern.
      in1 = 8'b1111_0000;
      for (int s = 0; s < 8; s++) begin
         sel1 = 3'(s);
         step();
         chk("nib_out", 64'(out1), (s >= 4) ? 64'd1 : 64'd0);
      end
      in1 = 8'b1010_1010; sel1 = 3'd0;
      step();
      chk("simul_change_out", 64'(out1), 64'd0);
      sel1 = 3'd1;
      step();
      chk("simul_next_out", 64'(out1), 64'd1);

      // Hold while invalid.
      sel1 = 3'd3;
      step();
      chk("hold_pre_out", 64'(out1), 64'd1);
      v1 = 1'b0; sel1 = 3'd0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_out", 64'(out1), 64'd1);
         chk("hold_selq", 64'(sq1), 64'd3);
         chk("hold_valid", 64'(ov1), 64'd0);
      end

      // Wide lanes.
      in8 = 64'h7766_5544_3322_1100; sel8 = 3'd5; v8 = 1'b1;
      step();
      chk("wide_out", 64'(out8), 64'h55);
      chk("wide_selq", 64'(sq8), 64'd5);
      in8 = in8 ^ 64'hFFFF_00FF_FFFF_FFFF;
      step();
      chk("wide_toggle_out", 64'(out8), 64'h55);
      in8 = 64'h0123_4567_89AB_CDEF; sel8 = 3'd2;
      step();
      chk("wide_sel2_out", 64'(out8), 64'hAB);

      // Mid-cycle asynchronous reset with a valid stream running.
      in1 = 8'b1010_1010; sel1 = 3'd1; v1 = 1'b1;
      step();
      chk("pre_rst_out", 64'(out1), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_out", 64'(out1), 64'd0);
      chk("async_rst_selq", 64'(sq1), 64'd0);
      chk("async_rst_valid", 64'(ov1), 64'd0);
      chk("async_rst_w8_out", 64'(out8), 64'd0);
      step();
      chk("rst_hold_out", 64'(out1), 64'd0);
      chk("rst_hold_valid", 64'(ov1), 64'd0);
      rst_n = 1'b1;
      step();
      chk("post_rst_out", 64'(out1), 64'd1);
      chk("post_rst_selq", 64'(sq1), 64'd1);
      chk("post_rst_valid", 64'(ov1), 64'd1);

      // Combinational mode responds with no clock edge.
      @(negedge clk);
      #1;
      selc = 3'd3;
      #0;
      #1;
      chk("comb_sel3_out", 64'(outc), 64'd0);
      selc = 3'd7; vc = 1'b0;
      #1;
      chk("comb_sel7_out", 64'(outc), 64'd1);
      chk("comb_valid_low", 64'(ovc), 64'd0);

      repeat (2) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_8to1.md
Name: mux_8to1

Overview:
- 8-input, 1-output selector. Lane `sel` of a packed 8-lane input bus drives the output.
- Output is registered by default, for use in timing-critical datapaths. A combinational mode is selectable by parameter.
- Single clock domain. Asynchronous active-low reset.
- Lane order: lane 0 = least significant WIDTH bits of `in`.

Parameters:
- WIDTH, 1, bit width of each input lane and of `out`.
- REG_OUT, 1, 1 = output registered (1-cycle latency); 0 = purely combinational path from `in`/`sel` to `out`.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in  input  8*WIDTH  packed lanes; lane k = in[k*WIDTH +: WIDTH].
- sel  input  3  lane select, 0..7.
- in_valid  input  1  qualifies in/sel for the current cycle.
- out  output  WIDTH  selected lane.
- out_valid  output  1  out holds a result from a valid sample.
- sel_q  output  3  select value that produced the current out.

Behaviour:
- Selection function: out = lane[sel]. All 8 codes of sel are legal; there are no don't-care codes.
- REG_OUT=1, sampling:
  - Every rising edge of clk samples in, sel and in_valid.
  - When in_valid=1: out <= lane[sel], sel_q <= sel, out_valid <= 1.
  - When in_valid=0: out and sel_q hold their previous values; out_valid <= 0.
- REG_OUT=1, latency: exactly 1 cycle from a valid sample to out/out_valid.
- REG_OUT=1, back-to-back: valid samples on consecutive cycles give consecutive results; no bubbles.
- REG_OUT=1, reset:
  - rst_n low asynchronously forces out=0, sel_q=0, out_valid=0, regardless of clk.
  - These values hold while rst_n is low.
  - The first sample is taken on the first rising edge with rst_n high.
  - Reset asserted mid-stream discards any in-flight result.
- REG_OUT=0:
  - out = lane[sel] combinationally; sel_q = sel; out_valid = in_valid.
  - Holds at all times, including during reset: no registers in the path, and clk/rst_n are unused.
- Width rule: no arithmetic. out is exactly WIDTH bits copied from the selected lane; there is no sign or zero extension.
- Simultaneous changes: when in and sel change in the same cycle, the registered result uses the values present at that edge.
- Unknown handling: an X/Z bit in the selected lane propagates to out. Unselected lanes never affect out.
- Implementation style:
  - Selection is a single case (or indexed part-select) over all 8 codes.
  - REG_OUT is handled by a generate branch.
  - No latches; a default branch assigns lane 0.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with in_valid=1 -> out=0, out_valid=0, sel_q=0 immediately, without waiting for clk. Release rst_n -> first valid result one edge later.
- Alternating pattern, WIDTH=1, REG_OUT=1: in=8'b10101010, in_valid=1, sel stepped 0..7 one per cycle -> out sequence 0,1,0,1,0,1,0,1, each one cycle after its sel, out_valid=1 throughout, sel_q tracking sel delayed by one cycle.
- Nibble pattern: in=8'b11110000, sel 0..7 -> out 0,0,0,0,1,1,1,1. Then change in to 8'b10101010 on the same edge that sel goes 7->0 -> next out=0, taken from the new in.
- Hold/valid: in=8'b10101010, sel=3 valid (out=1). Then in_valid=0 with sel=0 for 3 cycles -> out stays 1, sel_q stays 3, out_valid=0.
- Wide lanes, WIDTH=8: lanes 0..7 = 0x00,0x11,...,0x77, sel=5 -> out=0x55. Toggling unselected lanes leaves out unchanged.
- Combinational mode, REG_OUT=0: in=8'b11110000, sel=4 -> out=1 in the same delta cycle with no clock edge. rst_n=0 has no effect on out.
